// File: rtl/usb_tx_data_packetizer.sv
// usb_tx_data_packetizer: builds a USB DATAx byte stream (PID, payload, ~CRC16)
// and drives the neighbouring byte-parallel CRC16 engine.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start_i, pid_i, len_i        packet request (sampled in IDLE only)
//   busy_o, done_o, err_o        status: not idle, final CRC byte accepted, oversize start
//   pl_data_i/pl_valid_i/pl_ready_o   payload input stream
//   tx_data_o/tx_valid_o/tx_ready_i/tx_last_o   packet output stream
//   crc_clear_o, crc_data_o, crc_valid_o, crc_i   CRC engine hookup
module usb_tx_data_packetizer #(
    parameter int MAX_PAYLOAD = 1023,
    parameter int LEN_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       pid_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic [7:0]       pl_data_i,
    input  logic             pl_valid_i,
    output logic             pl_ready_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             tx_last_o,
    output logic             crc_clear_o,
    output logic [7:0]       crc_data_o,
    output logic             crc_valid_o,
    input  logic [15:0]      crc_i
);
    typedef enum logic [2:0] {IDLE, PID, DATA, CRC_WAIT, CRC_LO, CRC_HI} state_t;

    state_t           state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             wait_q, wait_d;
    logic [15:0]      crc_q, crc_d;
    logic             len_ok;
    logic             xfer;

    assign len_ok = len_i <= LEN_W'(MAX_PAYLOAD);
    assign xfer   = pl_valid_i && tx_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pid_q   <= '0;
            rem_q   <= '0;
            wait_q  <= 1'b0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            crc_q   <= crc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        rem_d       = rem_q;
        wait_d      = wait_q;
        crc_d       = crc_q;
        busy_o      = state_q != IDLE;
        done_o      = 1'b0;
        err_o       = 1'b0;
        pl_ready_o  = 1'b0;
        tx_data_o   = '0;
        tx_valid_o  = 1'b0;
        tx_last_o   = 1'b0;
        crc_clear_o = 1'b0;
        crc_data_o  = '0;
        crc_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gating keeps the combinational pulses quiet while reset is held
                if (start_i && rst_n) begin
                    if (len_ok) begin
                        pid_d       = pid_i;
                        rem_d       = len_i;
                        crc_clear_o = 1'b1;
                        state_d     = PID;
                    end else begin
                        err_o = 1'b1;
                    end
                end
            end
            PID: begin
                tx_data_o  = {~pid_q, pid_q};
                tx_valid_o = 1'b1;
                if (tx_ready_i) state_d = (rem_q != '0) ? DATA : CRC_WAIT;
            end
            DATA: begin
                tx_data_o  = pl_data_i;
                tx_valid_o = pl_valid_i;
                pl_ready_o = tx_ready_i;
                if (xfer) begin
                    crc_valid_o = 1'b1;
                    crc_data_o  = pl_data_i;
                    rem_d       = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = CRC_WAIT;
                end
            end
            CRC_WAIT: begin
                // two cycles cover the engine's two-edge pipeline after the last byte
                wait_d = ~wait_q;
                if (wait_q) begin
                    crc_d   = crc_i;
                    state_d = CRC_LO;
                end
            end
            CRC_LO: begin
                tx_data_o  = ~crc_q[7:0];
                tx_valid_o = 1'b1;
                if (tx_ready_i) state_d = CRC_HI;
            end
            CRC_HI: begin
                tx_data_o  = ~crc_q[15:8];
                tx_valid_o = 1'b1;
                tx_last_o  = 1'b1;
                if (tx_ready_i) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
